// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic: ALU-control decode, 32-bit ALU with N/Z/V flags,
// PC+4 / branch-target adders, and a registered copy of the last captured flags.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  aluop,
  input  logic [3:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic        flag_we,
  input  logic [31:0] pc,
  input  logic [31:0] br_off,
  output logic [2:0]  alu_ctl,
  output logic [31:0] result,
  output logic        zero,
  output logic [2:0]  flags,
  output logic [2:0]  flags_q,
  output logic [31:0] pc_plus4,
  output logic [31:0] br_target
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SLL = 3'b011;
  localparam logic [2:0] CTL_SRL = 3'b100;
  localparam logic [2:0] CTL_NOR = 3'b101;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  localparam logic [3:0] OP_RTYPE = 4'b0010;

  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        slt_bit;
  logic        v_flag;

  // ALU-control decode; anything not listed falls back to ADD
  always_comb begin
    alu_ctl = CTL_ADD;
    case (aluop)
      4'b0000: alu_ctl = CTL_ADD;
      4'b0001: alu_ctl = CTL_SUB;
      4'b0011: alu_ctl = CTL_SLL;
      4'b0100: alu_ctl = CTL_SRL;
      4'b0101: alu_ctl = CTL_OR;
      4'b0110: alu_ctl = CTL_AND;
      4'b0111: alu_ctl = CTL_SLT;
      OP_RTYPE: begin
        case (funct)
          4'b0000: alu_ctl = CTL_ADD;
          4'b0010: alu_ctl = CTL_SUB;
          4'b0100: alu_ctl = CTL_AND;
          4'b0101: alu_ctl = CTL_OR;
          4'b0111: alu_ctl = CTL_NOR;
          4'b1010: alu_ctl = CTL_SLT;
          default: alu_ctl = CTL_ADD;
        endcase
      end
      default: alu_ctl = CTL_ADD;
    endcase
  end

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[31] == b[31]) && (sum[31]  != a[31]);
  assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);
  // Signed less-than from the subtractor, correct even when a - b overflows
  assign slt_bit = diff[31] ^ sub_ovf;

  always_comb begin
    result = sum;
    case (alu_ctl)
      CTL_AND: result = a & b;
      CTL_OR:  result = a | b;
      CTL_ADD: result = sum;
      CTL_SUB: result = diff;
      CTL_SLT: result = {31'd0, slt_bit};
      CTL_SLL: result = b << shamt;
      CTL_SRL: result = b >> shamt;
      CTL_NOR: result = ~(a | b);
      default: result = sum;
    endcase
  end

  always_comb begin
    v_flag = 1'b0;
    case (alu_ctl)
      CTL_ADD: v_flag = add_ovf;
      CTL_SUB: v_flag = sub_ovf;
      default: v_flag = 1'b0;
    endcase
  end

  assign zero  = (result == 32'd0);
  assign flags = {result[31], zero, v_flag};

  // Previous instruction's flags for the branch-and-link logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (flag_we) begin
      flags_q <= flags;
    end
  end

  assign pc_plus4  = pc + 32'h4;
  assign br_target = pc_plus4 + br_off;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed boundary cases plus random stimulus
// checked against an arithmetic reference model and a flags_q expected queue.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic        flag_we;
  logic [31:0] pc;
  logic [31:0] br_off;
  logic [2:0]  alu_ctl;
  logic [31:0] result;
  logic        zero;
  logic [2:0]  flags;
  logic [2:0]  flags_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] exp_q[$];
  logic [2:0] held_flags = 3'b000;

  alu_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .aluop     (aluop),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .flag_we   (flag_we),
    .pc        (pc),
    .br_off    (br_off),
    .alu_ctl   (alu_ctl),
    .result    (result),
    .zero      (zero),
    .flags     (flags),
    .flags_q   (flags_q),
    .pc_plus4  (pc_plus4),
    .br_target (br_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // reference model
  function automatic logic [2:0] ref_ctl(input logic [3:0] op, input logic [3:0] fn);
    case (op)
      4'd1: return 3'b110;
      4'd3: return 3'b011;
      4'd4: return 3'b100;
      4'd5: return 3'b001;
      4'd6: return 3'b000;
      4'd7: return 3'b111;
      4'd2: begin
        case (fn)
          4'd2:  return 3'b110;
          4'd4:  return 3'b000;
          4'd5:  return 3'b001;
          4'd7:  return 3'b101;
          4'd10: return 3'b111;
          default: return 3'b010;
        endcase
      end
      default: return 3'b010;
    endcase
  endfunction

  function automatic void ref_alu(input logic [2:0] ctl, input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] sh, output logic [31:0] r, output logic v);
    longint sx;
    longint sy;
    longint wide;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    v  = 1'b0;
    case (ctl)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b101: r = ~(x | y);
      3'b011: r = y << sh;
      3'b100: r = y >> sh;
      3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
      3'b110: begin
        wide = sx - sy;
        r = wide[31:0];
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      default: begin
        wide = sx + sy;
        r = wide[31:0];
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
    endcase
  endfunction

  // driver: apply one instruction, check combinational outputs, then flags_q after the edge
  task automatic apply(input logic [3:0] op, input logic [3:0] fn, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [4:0] sh, input logic we,
                       input logic [31:0] ipc, input logic [31:0] ioff);
    logic [2:0]  ectl;
    logic [31:0] eres;
    logic        ev;
    logic [2:0]  efl;
    @(negedge clk);
    aluop = op; funct = fn; a = ia; b = ib; shamt = sh;
    flag_we = we; pc = ipc; br_off = ioff;
    #1;
    ectl = ref_ctl(op, fn);
    ref_alu(ectl, ia, ib, sh, eres, ev);
    efl = {eres[31], eres == 32'd0, ev};
    check("alu_ctl", {29'd0, alu_ctl}, {29'd0, ectl});
    check("result", result, eres);
    check("zero", {31'd0, zero}, {31'd0, eres == 32'd0});
    check("flags", {29'd0, flags}, {29'd0, efl});
    check("pc_plus4", pc_plus4, ipc + 32'd4);
    check("br_target", br_target, ipc + 32'd4 + ioff);
    if (we) held_flags = efl;
    exp_q.push_back(held_flags);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check("flags_q", {29'd0, flags_q}, {29'd0, exp_q.pop_front()});
  endtask

  logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000001};
  logic [3:0]  functs [6] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd10};
  logic [2:0]  fctls  [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b101, 3'b111};

  initial begin
    rst_n = 1'b0; aluop = 4'd0; funct = 4'd0; a = 32'd0; b = 32'd0;
    shamt = 5'd0; flag_we = 1'b0; pc = 32'd0; br_off = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags_q", {29'd0, flags_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // decode sweep
    for (int i = 0; i < 6; i++) begin
      apply(4'd2, functs[i], 32'h12345678, 32'h00FF00FF, 5'd3, 1'b0, 32'h100, 32'h8);
      check("rtype_ctl", {29'd0, alu_ctl}, {29'd0, fctls[i]});
    end
    apply(4'd2, 4'hF, 32'd1, 32'd2, 5'd0, 1'b0, 32'h0, 32'h0);
    check("rtype_default_ctl", {29'd0, alu_ctl}, 32'd2);
    apply(4'hF, 4'd2, 32'd1, 32'd2, 5'd0, 1'b0, 32'h0, 32'h0);
    check("aluop_default_ctl", {29'd0, alu_ctl}, 32'd2);

    // arithmetic boundaries
    apply(4'd0, 4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0);
    check("add_ovf_res", result, 32'h80000000);
    check("add_ovf_flags", {29'd0, flags}, 32'b101);
    apply(4'd1, 4'd0, 32'h80000000, 32'h1, 5'd0, 1'b0, 32'h0, 32'h0);
    check("sub_ovf_res", result, 32'h7FFFFFFF);
    check("sub_ovf_flags", {29'd0, flags}, 32'b001);
    apply(4'd1, 4'd0, 32'd5, 32'd5, 5'd0, 1'b0, 32'h0, 32'h0);
    check("sub_zero", {31'd0, zero}, 32'd1);
    check("sub_zero_flags", {29'd0, flags}, 32'b010);

    // SLT around overflow
    apply(4'd7, 4'd0, 32'h80000000, 32'h00000001, 5'd0, 1'b0, 32'h0, 32'h0);
    check("slt_min_vs_1", result, 32'd1);
    apply(4'd7, 4'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h0, 32'h0);
    check("slt_max_vs_m1", result, 32'd0);
    apply(4'd2, 4'd10, 32'hFFFFFFFF, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0);
    check("slt_m1_vs_0", result, 32'd1);

    // shifts and logic
    apply(4'd3, 4'd0, 32'h0, 32'h80000001, 5'd31, 1'b0, 32'h0, 32'h0);
    check("sll31", result, 32'h80000000);
    apply(4'd4, 4'd0, 32'h0, 32'h80000001, 5'd31, 1'b0, 32'h0, 32'h0);
    check("srl31", result, 32'h00000001);
    apply(4'd2, 4'd7, 32'hF0F0F0F0, 32'h0F0F0000, 5'd0, 1'b0, 32'h0, 32'h0);
    check("nor", result, 32'h00000F0F);

    // PC adders
    apply(4'd0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'hFFFFFFFC, 32'h0);
    check("pc_wrap", pc_plus4, 32'h0);
    apply(4'd0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h10, 32'hFFFFFFF8);
    check("br_back", br_target, 32'h0C);

    // flag register: capture something non-zero, then reset mid-cycle
    apply(4'd0, 4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b1, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_flags_q", {29'd0, flags_q}, 32'd0);
    held_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'd1, 4'd0, 32'd5, 32'd5, 5'd0, 1'b1, 32'h0, 32'h0);
    check("flags_q_capture", {29'd0, flags_q}, 32'b010);
    apply(4'd0, 4'd0, 32'h80000000, 32'h3, 5'd0, 1'b0, 32'h0, 32'h0);
    check("flags_q_hold", {29'd0, flags_q}, 32'b010);

    // random stimulus
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op;
      logic [31:0] ra;
      logic [31:0] rb;
      op = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 9) == 0) rb = ra;
      apply(op, 4'($urandom_range(0, 15)), ra, rb, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
